comma_align_sipo: RTL

Receive-side deserializer for the 8b/10b link. It shifts in the LSB-first serial stream produced by the transmit shift stage and hunts for the K28.5 comma at every bit offset. Once lock is achieved, it emits aligned 10-bit code groups to the 8b/10b decoder. Lock is declared after a configurable number of phase-consistent commas, and alignment is re-acquired after repeated misaligned commas.

---
 rtl/comma_align_sipo.sv | 119 +++++++++++
 1 files changed

// File: rtl/comma_align_sipo.sv
// Receive-side SIPO for the 8b/10b link: hunts for K28.5 at any bit offset,
// locks after consistent commas and emits aligned 10-bit code groups.
module comma_align_sipo #(
  parameter int unsigned LOCK_COMMAS    = 2,
  parameter int unsigned MISALIGN_LIMIT = 3,
  parameter logic [9:0]  COMMA_NEG      = 10'h17C,
  parameter logic [9:0]  COMMA_POS      = 10'h283
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       bit_en,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       comma_det,
  output logic       locked
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COMMAS);
  localparam logic [3:0] BAD_TARGET  = 4'(MISALIGN_LIMIT);
  // A single-comma lock requirement makes every realignment re-enter LOCKED.
  localparam state_t     REALIGN_STATE = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;

  state_t     state, state_n;
  logic [9:0] window, win_next;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [3:0] good_cnt, good_cnt_n;
  logic [3:0] bad_cnt, bad_cnt_n;
  logic       is_comma;
  logic       boundary;
  logic       emit;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    win_next   = {serial_in, window[9:1]};
    is_comma   = (win_next == COMMA_NEG) || (win_next == COMMA_POS);
    boundary   = bit_en && (bit_cnt == 4'd9);
    emit       = boundary && (state == LOCKED);
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    good_cnt_n = good_cnt;
    bad_cnt_n  = bad_cnt;

    if (bit_en) begin
      bit_cnt_n = (bit_cnt == 4'd9) ? '0 : bit_cnt + 4'd1;
      unique case (state)
        HUNT: begin
          if (is_comma) begin
            bit_cnt_n  = '0;
            good_cnt_n = 4'd1;
            state_n    = REALIGN_STATE;
          end
        end
        VERIFY: begin
          if (is_comma) begin
            if (boundary) begin
              good_cnt_n = sat_inc(good_cnt);
              if (sat_inc(good_cnt) == LOCK_TARGET) state_n = LOCKED;
            end else begin
              bit_cnt_n  = '0;
              good_cnt_n = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (is_comma) begin
            if (boundary) begin
              bad_cnt_n = '0;
            end else if (sat_inc(bad_cnt) == BAD_TARGET) begin
              bit_cnt_n  = '0;
              good_cnt_n = 4'd1;
              bad_cnt_n  = '0;
              state_n    = REALIGN_STATE;
            end else begin
              bad_cnt_n = sat_inc(bad_cnt);
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      window     <= '0;
      bit_cnt    <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      comma_det  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      good_cnt   <= good_cnt_n;
      bad_cnt    <= bad_cnt_n;
      locked     <= (state_n == LOCKED);
      word_valid <= emit;
      if (bit_en) window <= win_next;
      if (emit) begin
        word_out  <= win_next;
        comma_det <= is_comma;
      end
    end
  end

endmodule
